// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the core's data-memory request interface, used in place of
// the zero-latency data memory when the multi-cycle core is built. One
// load/store request is accepted at a time over a valid/ready handshake. A
// programmable number of wait states is inserted before the access happens,
// and the result is returned on a response channel that honours backpressure.
// Stores support byte, half-word and word lane enables.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words; byte addresses 0 .. 4*DEPTH_WORDS-1
//   WAIT_CYCLES  wait states between request acceptance and response (0..15)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset (also clears the whole memory)
//   req_valid  request present
//   req_ready  responder can accept a request (high only in IDLE)
//   req_we     00 read word, 01 store byte, 10 store half, 11 store word
//   req_addr   byte address
//   req_wdata  store data, right-aligned (byte in [7:0], half in [15:0])
//   rsp_valid  response present (high only in RESP)
//   rsp_ready  requester accepts the response
//   rsp_rdata  read data of the aligned word; 0 for stores and on error
//   rsp_err    misaligned or out-of-range access
//   DM0/DM4/DM8 live contents of words 0, 1 and 2 for debugging
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] DM0,
    output logic [31:0] DM4,
    output logic [31:0] DM8
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       wait_cnt;

    logic [1:0]       we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;

    logic [1:0]       acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [31:0]      word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             in_range;
    logic             misaligned;
    logic             acc_err;
    logic             do_store;
    logic [31:0]      cur_word;
    logic [31:0]      merged_word;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. The WAIT counter is loaded with
    // WAIT_CYCLES on acceptance and counts down; RESP is entered on the edge
    // after it has run out, which puts the response WAIT_CYCLES+1 edges after
    // the accepting edge. With no wait states the access happens on the
    // accepting edge itself.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on acceptance, decremented while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_INIT;
        end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request capture so the requester is free once the handshake completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Access decode. In IDLE the operands come straight from the request
    // port, which only matters for the zero-wait-state build where the access
    // happens on the accepting edge; otherwise the captured copy is used.
    always_comb begin
        acc_we    = (state == S_IDLE) ? req_we    : we_q;
        acc_addr  = (state == S_IDLE) ? req_addr  : addr_q;
        acc_wdata = (state == S_IDLE) ? req_wdata : wdata_q;

        word_idx  = {2'b00, acc_addr[31:2]};
        in_range  = word_idx < 32'(DEPTH_WORDS);
        mem_idx   = word_idx[IDX_W-1:0];

        misaligned = 1'b0;
        case (acc_we)
            2'b10:   misaligned = acc_addr[0];
            2'b11:   misaligned = |acc_addr[1:0];
            default: misaligned = 1'b0;
        endcase

        acc_err  = !in_range || misaligned;
        cur_word = in_range ? mem[mem_idx] : 32'd0;

        merged_word = cur_word;
        case (acc_we)
            2'b01: begin
                case (acc_addr[1:0])
                    2'd0:    merged_word[7:0]   = acc_wdata[7:0];
                    2'd1:    merged_word[15:8]  = acc_wdata[7:0];
                    2'd2:    merged_word[23:16] = acc_wdata[7:0];
                    default: merged_word[31:24] = acc_wdata[7:0];
                endcase
            end
            2'b10: begin
                if (acc_addr[1]) begin
                    merged_word[31:16] = acc_wdata[15:0];
                end else begin
                    merged_word[15:0]  = acc_wdata[15:0];
                end
            end
            2'b11: begin
                merged_word = acc_wdata;
            end
            default: begin
                merged_word = cur_word;
            end
        endcase

        do_store = enter_resp && (acc_we != 2'b00) && !acc_err;
    end

    // Memory array. Stores land only on the edge that enters RESP, so a
    // reset taken while waiting drops the store entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (do_store) begin
            mem[mem_idx] <= merged_word;
        end
    end

    // Response registers, loaded once at RESP entry and held while the
    // requester applies backpressure; read data is a snapshot, not live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_we == 2'b00 && !acc_err) ? cur_word : 32'd0;
        end
    end

    assign DM0 = mem[0];
    assign DM4 = mem[1];
    assign DM8 = mem[2];

endmodule
